// File: rtl/usb_pd_pkg.sv
// Shared constants for the USB-PD transmit scheduler: PD message types,
// FSM state encoding and microsecond-to-cycle conversion.
package usb_pd_pkg;

    // PD control message types used by the scheduler and its users
    localparam logic [3:0] PD_GOODCRC = 4'd1;
    localparam logic [3:0] PD_REQUEST = 4'd2;
    localparam logic [3:0] PD_ACCEPT  = 4'd3;
    localparam logic [3:0] PD_PS_RDY  = 4'd6;

    // All timers are 20-bit saturating counters
    localparam int unsigned          TIMER_W   = 20;
    localparam logic [TIMER_W-1:0]   TIMER_MAX = '1;

    // Scheduler FSM encoding
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_GAP      = 3'd1;
    localparam logic [2:0] ST_START    = 3'd2;
    localparam logic [2:0] ST_TX       = 3'd3;
    localparam logic [2:0] ST_WAIT_CRC = 3'd4;
    localparam logic [2:0] ST_DONE     = 3'd5;
    localparam logic [2:0] ST_FAIL     = 3'd6;

    // Number of clock cycles in 'us' microseconds at 'khz' kHz
    function automatic longint unsigned us_to_cycles(input longint unsigned us,
                                                     input longint unsigned khz);
        return (us * khz) / 64'd1000;
    endfunction

endpackage

// File: rtl/usb_pd_us_timer.sv
// 20-bit saturating cycle timer with synchronous clear, count enable and a
// terminal-count compare. 'done' already accounts for the cycle currently
// being counted, so a terminal of N fires on the N-th enabled cycle.
module usb_pd_us_timer
    import usb_pd_pkg::*;
(
    input  logic               clock,
    input  logic               nrst,
    input  logic               clear,
    input  logic               enable,
    input  logic [TIMER_W-1:0] terminal,
    output logic               done
);

    logic [TIMER_W-1:0] count;

    // Count enabled cycles, holding at the maximum instead of wrapping
    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != TIMER_MAX)) begin
            // NOTE: state registers use non-blocking assignments so every flop
            // samples pre-edge values, independent of block ordering.
            count <= count + 1'b1;
        end
    end

    // Terminal reached once this cycle's increment is included
    always_comb begin
        done = ({1'b0, count} + {{TIMER_W{1'b0}}, enable}) >= {1'b0, terminal};
    end

endmodule

// File: rtl/usb_pd_tx_sched.sv
// USB-PD transmit scheduler: arbitrates GoodCRC replies against user
// messages, enforces the inter-frame gap, handshakes with the PHY, waits
// for the partner's GoodCRC with retries, and maintains the MessageID.
module usb_pd_tx_sched
    import usb_pd_pkg::*;
#(
    parameter int unsigned system_khz     = 30000,
    parameter int unsigned ifg_us         = 25,
    parameter int unsigned crc_timeout_us = 1000,
    parameter int unsigned n_retry        = 2
) (
    input  logic       clock,
    input  logic       nrst,
    // GoodCRC reply request
    input  logic       gcrc_req,
    input  logic [2:0] gcrc_id,
    // User message request
    input  logic       msg_req,
    input  logic       msg_hrst,
    input  logic [2:0] msg_num,
    input  logic [3:0] msg_type,
    output logic       msg_ack,
    output logic       msg_done,
    output logic       msg_fail,
    // Receiver status
    input  logic       rx_busy,
    input  logic       rx_crc_valid,
    input  logic       rx_pkg_valid,
    input  logic [3:0] rx_type,
    input  logic [2:0] rx_num,
    input  logic [2:0] rx_id,
    // PHY transmit interface
    output logic       phy_start,
    input  logic       phy_busy,
    output logic       phy_hrst,
    output logic [2:0] phy_id,
    output logic [2:0] phy_num,
    output logic [3:0] phy_type,
    output logic       phy_word_sel,
    output logic [2:0] msg_id
);

    localparam longint unsigned GAP_CYC_L = us_to_cycles(64'(ifg_us), 64'(system_khz));
    localparam longint unsigned CRC_CYC_L = us_to_cycles(64'(crc_timeout_us), 64'(system_khz));
    localparam logic [TIMER_W-1:0] GAP_CYC = GAP_CYC_L[TIMER_W-1:0];
    localparam logic [TIMER_W-1:0] CRC_CYC = CRC_CYC_L[TIMER_W-1:0];
    localparam logic [7:0]         RETRY_MAX = 8'(n_retry);

    // Refuse to build with timer settings the 20-bit counter cannot reach
    if (GAP_CYC_L > 64'(TIMER_MAX)) begin : g_gap_range
        $error("usb_pd_tx_sched: ifg_us*system_khz/1000 exceeds 2^20-1 cycles");
    end
    if (CRC_CYC_L > 64'(TIMER_MAX)) begin : g_crc_range
        $error("usb_pd_tx_sched: crc_timeout_us*system_khz/1000 exceeds 2^20-1 cycles");
    end
    if (n_retry > 255) begin : g_retry_range
        $error("usb_pd_tx_sched: n_retry must not exceed 255");
    end

    logic [2:0]         state;
    logic [2:0]         state_nxt;
    logic               gcrc_pend;
    logic               gcrc_fresh;
    logic [2:0]         gcrc_pend_id;
    logic               is_gcrc;
    logic [7:0]         attempt;
    logic               crc_ok_q;
    logic               crc_hit;
    logic               launch_gcrc;
    logic               launch_msg;
    logic               retry;
    logic               tmr_clear;
    logic               tmr_enable;
    logic               tmr_done;
    logic [TIMER_W-1:0] tmr_terminal;

    // One timer serves both the bus-idle gap and the GoodCRC wait
    usb_pd_us_timer u_timer (
        .clock    (clock),
        .nrst     (nrst),
        .clear    (tmr_clear),
        .enable   (tmr_enable),
        .terminal (tmr_terminal),
        .done     (tmr_done)
    );

    // Timer control: count idle-bus cycles in GAP, all cycles in WAIT_CRC;
    // restart on bus activity, on a timeout, and in every other state
    always_comb begin
        tmr_enable   = ((state == ST_GAP) && !rx_busy) || (state == ST_WAIT_CRC);
        tmr_clear    = ((state != ST_GAP) && (state != ST_WAIT_CRC))
                     || ((state == ST_GAP) && rx_busy)
                     || ((state == ST_WAIT_CRC) && tmr_done);
        tmr_terminal = (state == ST_WAIT_CRC) ? CRC_CYC : GAP_CYC;
    end

    // GoodCRC qualification on the rising edge of a valid received frame
    always_comb begin
        crc_hit = rx_crc_valid && rx_pkg_valid && !crc_ok_q
               && (rx_type == PD_GOODCRC) && (rx_num == 3'd0) && (rx_id == msg_id);
    end

    // Next-state logic and per-transition strobes
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_nxt   = state;
        launch_gcrc = 1'b0;
        launch_msg  = 1'b0;
        retry       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (gcrc_pend || gcrc_req) begin
                    launch_gcrc = 1'b1;
                    state_nxt   = ST_GAP;
                end else if (msg_req) begin
                    launch_msg  = 1'b1;
                    state_nxt   = ST_GAP;
                end
            end
            ST_GAP: begin
                if (tmr_done) state_nxt = ST_START;
            end
            ST_START: begin
                if (phy_busy) state_nxt = ST_TX;
            end
            ST_TX: begin
                if (!phy_busy) state_nxt = (is_gcrc || phy_hrst) ? ST_DONE : ST_WAIT_CRC;
            end
            ST_WAIT_CRC: begin
                if (crc_hit) begin
                    state_nxt = ST_DONE;
                end else if (tmr_done) begin
                    if (attempt < RETRY_MAX) begin
                        retry     = 1'b1;
                        state_nxt = ST_GAP;
                    end else begin
                        state_nxt = ST_FAIL;
                    end
                end
            end
            ST_DONE:  state_nxt = ST_IDLE;
            ST_FAIL:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // State register and receive-valid edge history
    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            state    <= ST_IDLE;
            crc_ok_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            crc_ok_q <= rx_crc_valid && rx_pkg_valid;
        end
    end

    // Pending GoodCRC: stays set while being served and is released at its
    // DONE unless a newer request arrived after it was launched
    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            gcrc_pend    <= 1'b0;
            gcrc_fresh   <= 1'b0;
            gcrc_pend_id <= 3'd0;
        end else begin
            if (gcrc_req) gcrc_pend_id <= gcrc_id;
            if (launch_gcrc) begin
                gcrc_pend  <= 1'b1;
                gcrc_fresh <= 1'b0;
            end else if (gcrc_req) begin
                gcrc_pend  <= 1'b1;
                gcrc_fresh <= 1'b1;
            end else if ((state == ST_DONE) && is_gcrc) begin
                gcrc_pend  <= gcrc_fresh;
            end
        end
    end

    // Transaction capture: PHY fields, kind of transaction, acknowledge
    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            is_gcrc      <= 1'b0;
            msg_ack      <= 1'b0;
            phy_hrst     <= 1'b0;
            phy_id       <= 3'd0;
            phy_num      <= 3'd0;
            phy_type     <= 4'd0;
            phy_word_sel <= 1'b0;
        end else begin
            msg_ack <= launch_msg;
            if (launch_gcrc) begin
                is_gcrc      <= 1'b1;
                phy_hrst     <= 1'b0;
                phy_id       <= gcrc_req ? gcrc_id : gcrc_pend_id;
                phy_num      <= 3'd0;
                phy_type     <= PD_GOODCRC;
                phy_word_sel <= 1'b0;
            end else if (launch_msg) begin
                is_gcrc      <= 1'b0;
                phy_hrst     <= msg_hrst;
                phy_id       <= msg_id;
                phy_num      <= msg_num;
                phy_type     <= msg_type;
                phy_word_sel <= 1'b1;
            end
        end
    end

    // Retry bookkeeping and MessageID update on completed messages
    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            attempt <= 8'd0;
            msg_id  <= 3'd0;
        end else begin
            if (launch_msg) begin
                attempt <= 8'd0;
            end else if (retry) begin
                attempt <= attempt + 8'd1;
            end
            if ((state == ST_DONE) && !is_gcrc) begin
                msg_id <= phy_hrst ? 3'd0 : msg_id + 3'd1;
            end
        end
    end

    // State-decoded strobes
    assign phy_start = (state == ST_START);
    assign msg_done  = (state == ST_DONE) && !is_gcrc;
    assign msg_fail  = (state == ST_FAIL);

endmodule

// File: tb/tb_usb_pd_tx_sched.sv
// Scoreboard bench for usb_pd_tx_sched. Stimulus pushes the expected
// sequence of DUT events (PHY start with its fields, ack, done, fail);
// a monitor pops and compares each event as the DUT produces it.
// The DUT runs at 3 MHz so that 1 us = 3 cycles: gap 75, timeout 3000.
module tb_usb_pd_tx_sched;
    import usb_pd_pkg::*;

    localparam int SYS_KHZ    = 3000;
    localparam int GAP_CYC    = 75;
    localparam int CRC_CYC    = 3000;
    localparam int PHY_TX_CYC = 20;

    localparam logic [3:0] EV_PHY  = 4'd1;
    localparam logic [3:0] EV_ACK  = 4'd2;
    localparam logic [3:0] EV_DONE = 4'd3;
    localparam logic [3:0] EV_FAIL = 4'd4;

    localparam int SIG_ACK  = 0;
    localparam int SIG_DONE = 1;
    localparam int SIG_FAIL = 2;
    localparam int SIG_BUSY = 3;

    typedef struct packed {
        logic [3:0]  kind;
        logic [15:0] data;
    } ev_t;

    logic       clock = 1'b0;
    logic       nrst;
    logic       gcrc_req, msg_req, msg_hrst;
    logic [2:0] gcrc_id, msg_num;
    logic [3:0] msg_type;
    logic       msg_ack, msg_done, msg_fail;
    logic       rx_busy, rx_crc_valid, rx_pkg_valid;
    logic [3:0] rx_type;
    logic [2:0] rx_num, rx_id;
    logic       phy_start, phy_busy, phy_hrst, phy_word_sel;
    logic [2:0] phy_id, phy_num, msg_id;
    logic [3:0] phy_type;

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   start_cyc[$];
    ev_t  exp_q[$];

    usb_pd_tx_sched #(
        .system_khz     (SYS_KHZ),
        .ifg_us         (25),
        .crc_timeout_us (1000),
        .n_retry        (2)
    ) dut (
        .clock        (clock),
        .nrst         (nrst),
        .gcrc_req     (gcrc_req),
        .gcrc_id      (gcrc_id),
        .msg_req      (msg_req),
        .msg_hrst     (msg_hrst),
        .msg_num      (msg_num),
        .msg_type     (msg_type),
        .msg_ack      (msg_ack),
        .msg_done     (msg_done),
        .msg_fail     (msg_fail),
        .rx_busy      (rx_busy),
        .rx_crc_valid (rx_crc_valid),
        .rx_pkg_valid (rx_pkg_valid),
        .rx_type      (rx_type),
        .rx_num       (rx_num),
        .rx_id        (rx_id),
        .phy_start    (phy_start),
        .phy_busy     (phy_busy),
        .phy_hrst     (phy_hrst),
        .phy_id       (phy_id),
        .phy_num      (phy_num),
        .phy_type     (phy_type),
        .phy_word_sel (phy_word_sel),
        .msg_id       (msg_id)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] phy_word(input logic [2:0] id, input logic [2:0] num,
                                             input logic [3:0] typ, input logic hrst,
                                             input logic ws);
        return {4'b0, id, num, typ, hrst, ws};
    endfunction

    task automatic push(input logic [3:0] kind, input logic [15:0] data);
        exp_q.push_back('{kind: kind, data: data});
    endtask

    task automatic sb_compare(input logic [3:0] kind, input logic [15:0] data);
        ev_t e;
        if (exp_q.size() == 0) begin
            check("sb_unexpected_event", {12'b0, kind, data}, 32'h0);
        end else begin
            e = exp_q.pop_front();
            check($sformatf("sb_event_kind%0d", e.kind), {12'b0, kind, data},
                  {12'b0, e.kind, e.data});
        end
    endtask

    function automatic logic sig_val(input int sel);
        case (sel)
            SIG_ACK:  return msg_ack;
            SIG_DONE: return msg_done;
            SIG_FAIL: return msg_fail;
            default:  return phy_busy;
        endcase
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Bounded wait for a DUT signal level, sampled on the falling edge
    task automatic wait_sig(input int sel, input logic lvl, input int limit, input string name);
        logic found = 1'b0;
        for (int i = 0; i < limit && !found; i++) begin
            @(negedge clock);
            if (sig_val(sel) === lvl) found = 1'b1;
        end
        check({name, "_seen"}, {31'b0, found}, 32'd1);
    endtask

    task automatic wait_tx(input string name, input int limit);
        wait_sig(SIG_BUSY, 1'b1, limit, {name, "_busy_rise"});
        wait_sig(SIG_BUSY, 1'b0, PHY_TX_CYC + 10, {name, "_busy_fall"});
    endtask

    task automatic request_msg(input logic [3:0] t, input logic [2:0] n, input logic h,
                               input int limit);
        step();
        msg_req  = 1'b1;
        msg_type = t;
        msg_num  = n;
        msg_hrst = h;
        wait_sig(SIG_ACK, 1'b1, limit, "msg_ack");
        msg_req  = 1'b0;
    endtask

    task automatic crc_pulse(input logic [3:0] t, input logic [2:0] n, input logic [2:0] id);
        step();
        rx_crc_valid = 1'b1;
        rx_pkg_valid = 1'b1;
        rx_type      = t;
        rx_num       = n;
        rx_id        = id;
        step();
        rx_crc_valid = 1'b0;
        rx_pkg_valid = 1'b0;
    endtask

    // Normal message answered by a matching GoodCRC
    task automatic do_msg_ok(input logic [3:0] t, input logic [2:0] n, input logic [2:0] id);
        push(EV_ACK, 16'h0);
        push(EV_PHY, phy_word(id, n, t, 1'b0, 1'b1));
        push(EV_DONE, 16'h0);
        request_msg(t, n, 1'b0, 50);
        wait_tx("ok_tx", 300);
        repeat (20) step();
        crc_pulse(PD_GOODCRC, 3'd0, id);
        wait_sig(SIG_DONE, 1'b1, 10, "ok_done");
    endtask

    // PHY model: accepts phy_start after two cycles, then stays busy
    initial begin
        phy_busy = 1'b0;
        forever begin
            step();
            if (phy_start === 1'b1 && !phy_busy) begin
                repeat (2) @(posedge clock);
                #1 phy_busy = 1'b1;
                repeat (PHY_TX_CYC) @(posedge clock);
                #1 phy_busy = 1'b0;
            end
        end
    end

    // Monitor: every DUT event is matched against the scoreboard queue
    initial begin
        logic prev_start = 1'b0;
        forever begin
            @(negedge clock);
            if (nrst === 1'b1) begin
                if (phy_start && !prev_start) begin
                    start_cyc.push_back(cyc);
                    sb_compare(EV_PHY, phy_word(phy_id, phy_num, phy_type, phy_hrst, phy_word_sel));
                end
                if (msg_ack)  sb_compare(EV_ACK, 16'h0);
                if (msg_done) sb_compare(EV_DONE, 16'h0);
                if (msg_fail) sb_compare(EV_FAIL, 16'h0);
            end
            prev_start = phy_start && nrst;
        end
    end

    initial begin
        #(10 * 60000);
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int n0;
        int d;
        logic saw_start;
        logic [2:0] id;

        nrst = 1'b0;
        gcrc_req = 1'b0; gcrc_id = 3'd0;
        msg_req = 1'b0; msg_hrst = 1'b0; msg_num = 3'd0; msg_type = 4'd0;
        rx_busy = 1'b0; rx_crc_valid = 1'b0; rx_pkg_valid = 1'b0;
        rx_type = 4'd0; rx_num = 3'd0; rx_id = 3'd0;

        // Reset state: all outputs low
        #2;
        check("reset_outputs",
              {13'b0, msg_ack, msg_done, msg_fail, phy_start, phy_hrst, phy_id, phy_num,
               phy_type, phy_word_sel, msg_id}, 32'h0);
        repeat (3) step();
        nrst = 1'b1;
        repeat (3) step();

        // Request type 2 num 1 with id 0; wrong-id GoodCRC ignored, real one ~300 us
        n0 = start_cyc.size();
        push(EV_ACK, 16'h0);
        push(EV_PHY, phy_word(3'd0, 3'd1, PD_REQUEST, 1'b0, 1'b1));
        push(EV_DONE, 16'h0);
        request_msg(PD_REQUEST, 3'd1, 1'b0, 50);
        wait_tx("t1_tx", 300);
        repeat (100) step();
        crc_pulse(PD_GOODCRC, 3'd0, 3'd3);
        repeat (600) step();
        crc_pulse(PD_GOODCRC, 3'd0, 3'd0);
        wait_sig(SIG_DONE, 1'b1, 10, "t1_done");
        step();
        check("t1_msg_id", {29'b0, msg_id}, 32'd1);
        check("t1_start_count", start_cyc.size() - n0, 32'd1);

        // Hard reset from msg_id 1: done straight after TX, id back to 0
        push(EV_ACK, 16'h0);
        push(EV_PHY, phy_word(3'd1, 3'd0, 4'd0, 1'b1, 1'b1));
        push(EV_DONE, 16'h0);
        request_msg(4'd0, 3'd0, 1'b1, 50);
        wait_tx("t2_tx", 300);
        wait_sig(SIG_DONE, 1'b1, 4, "t2_hrst_done");
        step();
        check("t2_msg_id", {29'b0, msg_id}, 32'd0);

        // No GoodCRC: three transmissions with id 0, then fail, id unchanged
        n0 = start_cyc.size();
        push(EV_ACK, 16'h0);
        for (int i = 0; i < 3; i++) push(EV_PHY, phy_word(3'd0, 3'd1, PD_REQUEST, 1'b0, 1'b1));
        push(EV_FAIL, 16'h0);
        request_msg(PD_REQUEST, 3'd1, 1'b0, 50);
        wait_sig(SIG_FAIL, 1'b1, 3 * (CRC_CYC + 200), "t3_fail");
        step();
        check("t3_start_count", start_cyc.size() - n0, 32'd3);
        if (start_cyc.size() >= n0 + 3) begin
            for (int i = 0; i < 2; i++) begin
                d = start_cyc[n0 + i + 1] - start_cyc[n0 + i];
                check($sformatf("t3_spacing%0d_cycles_%0d", i, d),
                      {31'b0, (d >= CRC_CYC + GAP_CYC) && (d <= CRC_CYC + GAP_CYC + 60)}, 32'd1);
            end
        end
        check("t3_msg_id", {29'b0, msg_id}, 32'd0);

        // GoodCRC request id 5 together with msg_req: GoodCRC first
        push(EV_PHY, phy_word(3'd5, 3'd0, PD_GOODCRC, 1'b0, 1'b0));
        push(EV_ACK, 16'h0);
        push(EV_PHY, phy_word(3'd0, 3'd0, PD_PS_RDY, 1'b0, 1'b1));
        push(EV_DONE, 16'h0);
        step();
        gcrc_req = 1'b1; gcrc_id = 3'd5;
        msg_req = 1'b1; msg_type = PD_PS_RDY; msg_num = 3'd0; msg_hrst = 1'b0;
        step();
        gcrc_req = 1'b0;
        wait_sig(SIG_ACK, 1'b1, 400, "t4_msg_ack");
        msg_req = 1'b0;
        wait_tx("t4_tx", 300);
        repeat (20) step();
        crc_pulse(PD_GOODCRC, 3'd0, 3'd0);
        wait_sig(SIG_DONE, 1'b1, 10, "t4_done");
        step();
        check("t4_msg_id", {29'b0, msg_id}, 32'd1);

        // MessageID walk up to 7 and wrap to 0, then hard reset keeps 0
        for (int i = 1; i < 7; i++) begin
            id = 3'(i);
            do_msg_ok(PD_ACCEPT, 3'd0, id);
        end
        step();
        check("t5_msg_id_7", {29'b0, msg_id}, 32'd7);
        do_msg_ok(PD_ACCEPT, 3'd0, 3'd7);
        step();
        check("t5_msg_id_wrap", {29'b0, msg_id}, 32'd0);
        push(EV_ACK, 16'h0);
        push(EV_PHY, phy_word(3'd0, 3'd0, 4'd0, 1'b1, 1'b1));
        push(EV_DONE, 16'h0);
        request_msg(4'd0, 3'd0, 1'b1, 50);
        wait_tx("t5_hrst_tx", 300);
        wait_sig(SIG_DONE, 1'b1, 4, "t5_hrst_done");
        step();
        check("t5_msg_id_hrst", {29'b0, msg_id}, 32'd0);

        // rx_busy activity in GAP restarts the 25 us idle count;
        // GoodCRC request during WAIT_CRC is served afterwards
        push(EV_ACK, 16'h0);
        push(EV_PHY, phy_word(3'd0, 3'd1, PD_REQUEST, 1'b0, 1'b1));
        push(EV_DONE, 16'h0);
        push(EV_PHY, phy_word(3'd2, 3'd0, PD_GOODCRC, 1'b0, 1'b0));
        rx_busy = 1'b1;
        request_msg(PD_REQUEST, 3'd1, 1'b0, 50);
        saw_start = 1'b0;
        rx_busy = 1'b0;
        repeat (40) begin step(); saw_start |= phy_start; end
        rx_busy = 1'b1;
        repeat (3) begin step(); saw_start |= phy_start; end
        rx_busy = 1'b0;
        repeat (60) begin step(); saw_start |= phy_start; end
        rx_busy = 1'b1;
        step();
        saw_start |= phy_start;
        check("t6_no_early_start", {31'b0, saw_start}, 32'd0);
        rx_busy = 1'b0;
        d = 0;
        while (phy_start !== 1'b1 && d < 200) begin step(); d++; end
        check("t6_gap_after_last_fall", d, GAP_CYC);
        wait_tx("t6_tx", 20);
        repeat (10) step();
        gcrc_req = 1'b1; gcrc_id = 3'd2;
        step();
        gcrc_req = 1'b0;
        repeat (50) step();
        crc_pulse(PD_GOODCRC, 3'd0, 3'd0);
        wait_sig(SIG_DONE, 1'b1, 10, "t6_done");
        wait_tx("t6_gcrc_tx", 300);
        step();
        check("t6_msg_id", {29'b0, msg_id}, 32'd1);

        // Reset while waiting for GoodCRC: outputs cleared at once, no pulses
        push(EV_ACK, 16'h0);
        push(EV_PHY, phy_word(3'd1, 3'd1, PD_REQUEST, 1'b0, 1'b1));
        request_msg(PD_REQUEST, 3'd1, 1'b0, 50);
        wait_tx("t7_tx", 300);
        repeat (50) step();
        #2 nrst = 1'b0;
        #1;
        check("t7_reset_outputs",
              {13'b0, msg_ack, msg_done, msg_fail, phy_start, phy_hrst, phy_id, phy_num,
               phy_type, phy_word_sel, msg_id}, 32'h0);
        repeat (3) step();
        nrst = 1'b1;
        repeat (40) step();
        check("t7_queue_empty", exp_q.size(), 32'd0);
        do_msg_ok(PD_REQUEST, 3'd1, 3'd0);
        step();
        check("t7_msg_id_after", {29'b0, msg_id}, 32'd1);

        repeat (20) step();
        check("sb_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/usb_pd_tx_sched.md
USB_PD_TX_SCHED -- requirements
Module: usb_pd_tx_sched

Interface
REQ-001 SHALL have parameter system_khz, default 30000, clock frequency in kHz.
REQ-002 SHALL have parameter ifg_us, default 25, minimum bus-idle gap before any transmit start.
REQ-003 SHALL have parameter crc_timeout_us, default 1000, GoodCRC wait per attempt.
REQ-004 SHALL have parameter n_retry, default 2, retransmissions after the first attempt.
REQ-005 SHALL have ports, clock and reset first: clock in 1 sole clock; nrst in 1 reset, asynchronous, active-low.
REQ-006 SHALL have ports: gcrc_req in 1 GoodCRC request pulse; gcrc_id in 3 ID to echo.
REQ-007 SHALL have ports: msg_req in 1 level request; msg_hrst in 1 hard reset; msg_num in 3 data-object count; msg_type in 4 type; msg_ack out 1; msg_done out 1; msg_fail out 1.
REQ-008 SHALL have ports: rx_busy in 1; rx_crc_valid in 1; rx_pkg_valid in 1; rx_type in 4; rx_num in 3; rx_id in 3.
REQ-009 SHALL have ports: phy_start out 1; phy_busy in 1; phy_hrst out 1; phy_id out 3; phy_num out 3; phy_type out 4; phy_word_sel out 1 (0 = zero payload, 1 = requester payload).
REQ-010 SHALL have port msg_id out 3, current transmit MessageID.

Function
REQ-011 SHALL use states IDLE, GAP, START, TX, WAIT_CRC, DONE, FAIL.
REQ-012 SHALL latch gcrc_req and gcrc_id into gcrc_pend in any state. A new gcrc_req overwrites the pending ID.
REQ-013 In IDLE, gcrc_pend SHALL win over msg_req. A simultaneous gcrc_req also wins.
REQ-014 SHALL accept msg_req only in IDLE with gcrc_pend clear.
- msg_ack: 1-cycle pulse.
- msg_num, msg_type and msg_hrst are captured on that cycle.
REQ-015 SHALL drive phy fields for a GoodCRC transaction as: type 1, num 0, id = latched gcrc_id, hrst 0, word_sel 0.
REQ-016 SHALL drive phy fields for a message as: captured type/num, id = msg_id, hrst = captured msg_hrst, word_sel 1.
REQ-017 GAP SHALL count ifg_us*system_khz/1000 consecutive cycles with rx_busy low.
- Any rx_busy high restarts the count.
- Count complete -> START.
REQ-018 START SHALL hold phy_start high until phy_busy is sampled high, then drop phy_start -> TX.
REQ-019 TX SHALL wait for phy_busy low.
- GoodCRC or hard reset -> DONE.
- Other message -> WAIT_CRC with the timer cleared.
REQ-020 WAIT_CRC SHALL qualify only on the rising edge of (rx_crc_valid & rx_pkg_valid) with rx_type==1, rx_num==0 and rx_id==msg_id.
- Qualified -> DONE.
- A mismatched ID SHALL be ignored.
REQ-021 WAIT_CRC timeout (crc_timeout_us*system_khz/1000 cycles):
- Attempt count < n_retry -> increment count, GAP, same msg_id.
- Otherwise -> FAIL.
REQ-022 DONE SHALL return to IDLE after one cycle.
- Message: 1-cycle msg_done pulse.
- Message success (not hard reset): msg_id increments modulo 8 (7 wraps to 0).
- Hard reset: msg_id cleared to 0.
- GoodCRC: gcrc_pend cleared, no msg_done.
REQ-023 FAIL SHALL pulse msg_fail for 1 cycle, leave msg_id unchanged, then -> IDLE.
REQ-024 A gcrc_req arriving mid-transaction SHALL be served from IDLE after the current transaction ends.
REQ-025 All timers SHALL be 20-bit saturating counters.
REQ-026 Parameter combinations exceeding 2^20-1 cycles SHALL be an elaboration error.

Reset
REQ-027 On nrst low the block SHALL, asynchronously:
- set state to IDLE;
- drive every output to 0, including msg_id = 0;
- clear gcrc_pend, attempt count and timers.
REQ-028 Reset mid-transaction SHALL abandon it with no msg_done or msg_fail pulse.

Structure
REQ-029 Package usb_pd_pkg SHALL hold:
- PD message type constants: GoodCRC=1, Request=2, Accept=3, PS_RDY=6;
- the state encoding;
- a cycles-from-microseconds constant function.
REQ-030 SHALL instantiate one sub-module usb_pd_us_timer (clear, enable, terminal-count compare), shared by GAP and WAIT_CRC.

Verification
REQ-031 Request type 2, num 1, msg_id 0, GoodCRC id 0 returned at 300 us -> msg_done; msg_id becomes 1; exactly one phy_start.
REQ-032 No GoodCRC returned -> 3 transmissions spaced ~1025 us apart, all with id 0; then msg_fail; msg_id stays 0.
REQ-033 gcrc_req id 5 and msg_req in the same cycle -> GoodCRC sent first (phy_id 5, word_sel 0); msg_ack only after its DONE.
REQ-034 msg_id 7, successful message -> msg_id 0; then a msg_hrst transaction -> msg_done without WAIT_CRC; msg_id 0.
REQ-035 rx_busy toggling during GAP -> phy_start only 25 us (750 cycles) after the last rx_busy fall.
REQ-036 nrst asserted in WAIT_CRC -> all outputs 0 immediately; no msg_done or msg_fail pulse; next request starts from IDLE.
